// File: rtl/seg7_scan_mux.sv
// Single-digit 7-segment driver: static nibble views, lamp test/blank, and
// timed auto-scan of the ALU result and flags one hex digit at a time.
module seg7_scan_mux #(
  parameter int DWELL = 5_000_000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       ena,
  input  logic [7:0] f,
  input  logic [7:0] flags,
  input  logic [2:0] sel,
  output logic [7:0] seg,
  output logic [2:0] digit
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [2:0] {
    HI    = 3'd0,
    LO    = 3'd1,
    FHI   = 3'd2,
    FLO   = 3'd3,
    BLANK = 3'd4
  } state_t;

  logic [2:0]    sel_q;
  logic [7:0]    f_s;
  logic [7:0]    flags_s;
  state_t        state;
  logic [CW-1:0] cnt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Mode 4 drops straight from LO to BLANK; mode 5 detours through the flags.
  function automatic state_t next_state(input logic [2:0] mode, input state_t st);
    case (st)
      HI:      next_state = LO;
      LO:      next_state = mode[0] ? FHI : BLANK;
      FHI:     next_state = FLO;
      FLO:     next_state = BLANK;
      default: next_state = HI;
    endcase
  endfunction

  function automatic logic [7:0] decode(input logic [2:0] mode, input state_t st,
                                        input logic [7:0] fv, input logic [7:0] fl);
    case (mode)
      3'd0: decode = {1'b0, hex7(fv[3:0])};
      3'd1: decode = {1'b0, hex7(fv[7:4])};
      3'd2: decode = {1'b0, hex7(fl[7:4])};
      3'd3: decode = {1'b0, hex7(fl[3:0])};
      3'd4, 3'd5: begin
        case (st)
          HI:      decode = {1'b1, hex7(fv[7:4])};
          LO:      decode = {1'b0, hex7(fv[3:0])};
          FHI:     decode = {1'b1, hex7(fl[7:4])};
          FLO:     decode = {1'b0, hex7(fl[3:0])};
          default: decode = 8'h00;
        endcase
      end
      3'd6:    decode = 8'hFF;
      default: decode = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sel_q   <= 3'd0;
      f_s     <= 8'h00;
      flags_s <= 8'h00;
      state   <= HI;
      cnt     <= '0;
      seg     <= 8'h00;
      digit   <= 3'd0;
    end else if (ena) begin
      seg   <= decode(sel_q, state, f_s, flags_s);
      digit <= state;
      if (sel != sel_q) begin
        sel_q   <= sel;
        state   <= HI;
        cnt     <= '0;
        f_s     <= f;
        flags_s <= flags;
      end else if (sel_q == 3'd4 || sel_q == 3'd5) begin
        if (cnt == LAST) begin
          cnt   <= '0;
          state <= next_state(sel_q, state);
          // Snapshot only at frame start so a frame never mixes two inputs.
          if (state == BLANK) begin
            f_s     <= f;
            flags_s <= flags;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        state   <= HI;
        cnt     <= '0;
        f_s     <= f;
        flags_s <= flags;
      end
    end
  end

endmodule
